// File: rtl/qqspi_target_pkg.sv
// Shared opcodes, state encoding and opcode-classification helpers for the qqspi target.
package qqspi_target_pkg;

  localparam logic [7:0] CMD_READ           = 8'h03;
  localparam logic [7:0] CMD_WRITE          = 8'h02;
  localparam logic [7:0] CMD_FAST_READ_QUAD = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE     = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_READ) || (c == CMD_WRITE) ||
           (c == CMD_FAST_READ_QUAD) || (c == CMD_QUAD_WRITE);
  endfunction

  function automatic logic cmd_is_quad(input logic [7:0] c);
    return (c == CMD_FAST_READ_QUAD) || (c == CMD_QUAD_WRITE);
  endfunction

  function automatic logic cmd_is_read(input logic [7:0] c);
    return (c == CMD_READ) || (c == CMD_FAST_READ_QUAD);
  endfunction

endpackage

// File: rtl/qqspi_target_sync.sv
// Brings the asynchronous SPI pins into clk and derives sclk edge and select/deselect pulses.
module qqspi_target_sync #(
  parameter logic CEN_NPOL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cen,
  input  logic       sclk,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_s,
  output logic       sel_pulse,
  output logic       desel_pulse,
  output logic       sclk_rise,
  output logic       sclk_fall
);

  // Polarity folded in before the flops so a cleared synchroniser always means "deselected".
  logic       sel_raw;
  logic [2:0] sel_ff;
  logic [2:0] sclk_ff;
  logic [3:0] sio_ff1;
  logic [3:0] sio_ff2;

  assign sel_raw = cen ^ ~CEN_NPOL;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_ff  <= '0;
      sclk_ff <= '0;
      sio_ff1 <= '0;
      sio_ff2 <= '0;
    end else begin
      sel_ff  <= {sel_ff[1:0], sel_raw};
      sclk_ff <= {sclk_ff[1:0], sclk};
      sio_ff1 <= sio_i;
      sio_ff2 <= sio_ff1;
    end
  end

  assign sio_s       = sio_ff2;
  assign sel_pulse   = sel_ff[1] & ~sel_ff[2];
  assign desel_pulse = ~sel_ff[1] & sel_ff[2];
  assign sclk_rise   = sclk_ff[1] & ~sclk_ff[2];
  assign sclk_fall   = ~sclk_ff[1] & sclk_ff[2];

endmodule

// File: rtl/qqspi_target.sv
// qqspi target: decodes serial/quad read and write opcodes and bridges them to a byte memory port.
//  state  | meaning
//  IDLE   | deselected, waiting for select
//  CMD    | shifting in the 8-bit opcode on sio[0]
//  ADDR   | shifting in the 24-bit address (serial or quad)
//  DUMMY  | quad-read turnaround, lines released
//  RDATA  | driving read data on sclk fall
//  WDATA  | collecting write bytes, posting them to memory
//  IGNORE | unsupported opcode, idle until deselect
module qqspi_target
  import qqspi_target_pkg::*;
#(
  parameter logic CEN_NPOL  = 1'b0,
  parameter int   ADDR_W    = 24,
  parameter int   DUMMY_CYC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cen,
  input  logic              sclk,
  input  logic [3:0]        sio_i,
  output logic [3:0]        sio_o,
  output logic [3:0]        sio_oe,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              underrun,
  output logic              bad_cmd
);

  localparam logic [4:0]        DUMMY_LAST = 5'(DUMMY_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_t      state, state_next;
  logic [3:0]  sio_s;
  logic        sel_pulse, desel_pulse, sclk_rise, sclk_fall;
  logic [4:0]  cnt;
  logic [2:0]  out_cnt;
  logic [7:0]  sin, sout, rd_buf, cmd_q;
  logic [23:0] addr_q;
  logic        rd_full;

  logic        quad, addr_last, byte_last, wr_pending;
  logic [7:0]  cmd_fin, byte_fin;
  logic [23:0] addr_fin;

  qqspi_target_sync #(.CEN_NPOL(CEN_NPOL)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .cen         (cen),
    .sclk        (sclk),
    .sio_i       (sio_i),
    .sio_s       (sio_s),
    .sel_pulse   (sel_pulse),
    .desel_pulse (desel_pulse),
    .sclk_rise   (sclk_rise),
    .sclk_fall   (sclk_fall)
  );

  assign quad       = cmd_is_quad(cmd_q);
  assign cmd_fin    = {sin[6:0], sio_s[0]};
  assign byte_fin   = quad ? {sin[3:0], sio_s} : {sin[6:0], sio_s[0]};
  assign addr_fin   = quad ? {addr_q[19:0], sio_s} : {addr_q[22:0], sio_s[0]};
  assign addr_last  = (cnt == (quad ? 5'd5 : 5'd23));
  assign byte_last  = (cnt == (quad ? 5'd1 : 5'd7));
  assign wr_pending = mem_valid & ~mem_ready;
  assign busy       = (state != ST_IDLE) && (state != ST_IGNORE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (sel_pulse) state_next = ST_CMD;
      ST_CMD:   if (sclk_rise && cnt == 5'd7)
                  state_next = cmd_known(cmd_fin) ? ST_ADDR : ST_IGNORE;
      ST_ADDR:  if (sclk_rise && addr_last) begin
                  if (!cmd_is_read(cmd_q))           state_next = ST_WDATA;
                  else if (quad && DUMMY_CYC != 0)   state_next = ST_DUMMY;
                  else                               state_next = ST_RDATA;
                end
      ST_DUMMY: if (sclk_rise && cnt == DUMMY_LAST) state_next = ST_RDATA;
      default:  ;
    endcase
    if (desel_pulse) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; out_cnt <= '0; sin <= '0; sout <= '0; rd_buf <= '0; cmd_q <= '0;
      addr_q <= '0; rd_full <= 1'b0; sio_o <= '0; sio_oe <= '0;
      mem_valid <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      underrun <= 1'b0; bad_cmd <= 1'b0;
    end else begin
      bad_cmd <= 1'b0;
      if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
        if (!mem_we) begin
          rd_buf  <= mem_rdata;
          rd_full <= 1'b1;
        end
      end
      case (state)
        ST_IDLE: if (sel_pulse) begin
          underrun <= 1'b0;
          cnt      <= '0;
          out_cnt  <= '0;
          rd_full  <= 1'b0;
          if (sclk_rise) begin
            sin <= cmd_fin;
            cnt <= 5'd1;
          end
        end
        ST_CMD: if (sclk_rise) begin
          sin <= cmd_fin;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt     <= '0;
            cmd_q   <= cmd_fin;
            bad_cmd <= ~cmd_known(cmd_fin);
          end
        end
        ST_ADDR: if (sclk_rise) begin
          addr_q <= addr_fin;
          cnt    <= cnt + 5'd1;
          if (addr_last) begin
            cnt <= '0;
            if (cmd_is_read(cmd_q)) begin
              mem_valid <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= addr_fin[ADDR_W-1:0];
              addr_q[ADDR_W-1:0] <= addr_fin[ADDR_W-1:0] + ADDR_ONE;
            end
          end
        end
        ST_DUMMY: if (sclk_rise) cnt <= cnt + 5'd1;
        ST_RDATA: if (sclk_fall) begin
          if (out_cnt != 3'd0) begin
            sio_o   <= quad ? sout[7:4] : {2'b00, sout[7], 1'b0};
            sout    <= quad ? {sout[3:0], 4'h0} : {sout[6:0], 1'b0};
            out_cnt <= out_cnt - 3'd1;
          end else if (rd_full) begin
            // Consuming the buffered byte immediately prefetches the next address.
            sio_o     <= quad ? rd_buf[7:4] : {2'b00, rd_buf[7], 1'b0};
            sout      <= quad ? {rd_buf[3:0], 4'h0} : {rd_buf[6:0], 1'b0};
            out_cnt   <= quad ? 3'd1 : 3'd7;
            rd_full   <= 1'b0;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= addr_q[ADDR_W-1:0];
            addr_q[ADDR_W-1:0] <= addr_q[ADDR_W-1:0] + ADDR_ONE;
          end else begin
            sio_o    <= '0;
            sout     <= '0;
            out_cnt  <= quad ? 3'd1 : 3'd7;
            underrun <= 1'b1;
          end
        end
        ST_WDATA: if (sclk_rise) begin
          sin <= byte_fin;
          cnt <= cnt + 5'd1;
          if (byte_last) begin
            cnt <= '0;
            if (wr_pending) begin
              underrun <= 1'b1;
            end else begin
              mem_valid <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= byte_fin;
              mem_addr  <= addr_q[ADDR_W-1:0];
              addr_q[ADDR_W-1:0] <= addr_q[ADDR_W-1:0] + ADDR_ONE;
            end
          end
        end
        default: ;
      endcase
      if (desel_pulse) begin
        cnt     <= '0;
        out_cnt <= '0;
        rd_full <= 1'b0;
        sio_o   <= '0;
        if (!mem_we) mem_valid <= 1'b0;
      end
      if (state_next == ST_RDATA) sio_oe <= quad ? 4'hF : 4'h2;
      else                        sio_oe <= 4'h0;
    end
  end

endmodule
